// File: rtl/baud_cfg_ctrl.sv
// baud_cfg_ctrl: sequences a baud-rate change into tick_generator.
// Takes a validated request, holds off new frames and waits for both
// engines to drain. It then applies the code and waits for tx_tick to
// settle before it reports done.
// Handshake: a request transfers on a rising clk edge where
// cfg_valid && cfg_ready. cfg_ready is high only while the FSM is in IDLE.
// The done and err pulses appear one cycle after the DONE/ERR state, in the
// same cycle that cfg_ready returns high.
module baud_cfg_ctrl #(
    parameter int BAUD_W        = 17,
    parameter int DRAIN_TIMEOUT = 65535,
    parameter int SETTLE_TICKS  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [BAUD_W-1:0] cfg_baud,
    output logic              cfg_ready,
    input  logic              tx_busy,
    input  logic              rx_busy,
    input  logic              tx_tick,
    output logic [BAUD_W-1:0] baud_rate,
    output logic              frame_hold,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [1:0]        err_code,
    output logic [2:0]        dbg_state
);

    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE_TICKS + 1);

    localparam logic [BAUD_W-1:0] BAUD_RST  = BAUD_W'(9600);
    localparam logic [DW-1:0]     DRAIN_END = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [DW-1:0]     DRAIN_MAX = DW'(DRAIN_TIMEOUT);
    localparam logic [SW-1:0]     TICK_END  = SW'(SETTLE_TICKS - 1);
    localparam logic [SW-1:0]     TICK_MAX  = SW'(SETTLE_TICKS);
    localparam logic [1:0]        ERR_CODE  = 2'b01;
    localparam logic [1:0]        ERR_TMO   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_DRAIN  = 3'd2,
        S_APPLY  = 3'd3,
        S_SETTLE = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t            state;
    logic [BAUD_W-1:0] req;
    logic [DW-1:0]     drain_cnt;
    logic [SW-1:0]     tick_cnt;
    logic [1:0]        err_pend;

    // Only the rates tick_generator supports are accepted.
    function automatic logic code_ok(input logic [BAUD_W-1:0] c);
        case (c)
            BAUD_W'(4800), BAUD_W'(9600), BAUD_W'(14400), BAUD_W'(19200),
            BAUD_W'(38400), BAUD_W'(57600), BAUD_W'(115200), BAUD_W'(128000):
                code_ok = 1'b1;
            default:
                code_ok = 1'b0;
        endcase
    endfunction

    assign dbg_state = state;

    // Sequencing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            req        <= BAUD_RST;
            baud_rate  <= BAUD_RST;
            cfg_ready  <= 1'b1;
            frame_hold <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            err_code   <= 2'b00;
            err_pend   <= 2'b00;
            drain_cnt  <= '0;
            tick_cnt   <= '0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        req       <= cfg_baud;
                        cfg_ready <= 1'b0;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!code_ok(req)) begin
                        err_pend <= ERR_CODE;
                        state    <= S_ERR;
                    end else if (req == baud_rate) begin
                        // Nothing to change, so the engines are never held off.
                        state <= S_DONE;
                    end else begin
                        frame_hold <= 1'b1;
                        drain_cnt  <= '0;
                        state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Both engines idle on the last allowed cycle still wins.
                    if (!tx_busy && !rx_busy) begin
                        state <= S_APPLY;
                    end else if (drain_cnt == DRAIN_END) begin
                        err_pend   <= ERR_TMO;
                        frame_hold <= 1'b0;
                        state      <= S_ERR;
                    end
                    if (drain_cnt != DRAIN_MAX) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_APPLY: begin
                    // A tick seen here is ignored; the generator reloads first.
                    baud_rate <= req;
                    tick_cnt  <= '0;
                    state     <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (tx_tick) begin
                        if (tick_cnt == TICK_END) begin
                            state <= S_DONE;
                        end
                        if (tick_cnt != TICK_MAX) begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    cfg_done   <= 1'b1;
                    frame_hold <= 1'b0;
                    cfg_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                S_ERR: begin
                    cfg_err    <= 1'b1;
                    err_code   <= err_pend;
                    frame_hold <= 1'b0;
                    cfg_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    cfg_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
